// File: rtl/code_frame_rx_pkg.sv
// Shared definitions for the serial code-frame receiver.
// Contents: receiver state encoding, data width, tick counter width helper.
package code_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int unsigned DATA_BITS = 8;

  // Width of a counter that has to hold 0 .. clks-1.
  function automatic int unsigned tick_width(input int unsigned clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/code_frame_rx_if.sv
// Byte delivery channel from the serial receiver to the decoder stage.
// Signals: out_data (byte), out_valid (byte pending), out_ready (decoder accepts).
// master: receiver side; slave: decoder side.
interface code_frame_rx_if;
  import code_rx_pkg::*;

  logic [DATA_BITS-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/code_frame_rx_sync.sv
// Two-flop synchronizer for an asynchronous input pin.
// Ports: clk, rst (sync, active high, loads 1 = idle line), d (async in),
// q (synchronized out, 2 cycles latency).
module sync_ff2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/code_frame_rx.sv
// Serial front-end for the decoder: receives start / 8 data (LSB first) /
// optional even parity / stop frames, hands good bytes to the decoder through
// a one-entry valid/ready holding register and keeps sticky error flags.
// Ports: clk, rst (sync, active high), rx_in (async serial, idle high),
// dec (master side of the byte channel), err_parity/err_frame/err_overrun
// (sticky), clear_err (clears the flags), busy (receiver not idle).
module code_frame_rx
  import code_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_EN    = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_in,
  code_frame_rx_if.master dec,
  output logic            err_parity,
  output logic            err_frame,
  output logic            err_overrun,
  input  logic            clear_err,
  output logic            busy
);
  localparam int unsigned     TW       = tick_width(CLKS_PER_BIT);
  localparam int unsigned     BW       = $clog2(DATA_BITS);
  localparam logic [TW-1:0]   HALF     = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0]   LAST     = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]   LAST_BIT = BW'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state, state_n;
  logic [TW-1:0]        cnt, cnt_n;
  logic [BW-1:0]        bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_bad, par_bad_n;
  logic                 good, frame_evt, par_evt;
  logic [DATA_BITS-1:0] hold_data;
  logic                 hold_valid;

  sync_ff2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bad <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      par_bad <= par_bad_n;
    end
  end

  // The start bit is checked half a bit in, and DATA is entered with the
  // counter reloaded, so every later sample (at LAST) lands mid-bit.
  always_comb begin
    state_n   = state;
    cnt_n     = (cnt == LAST) ? '0 : cnt + 1'b1;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    par_bad_n = par_bad;
    good      = 1'b0;
    frame_evt = 1'b0;
    par_evt   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) begin
          state_n   = START;
          par_bad_n = 1'b0;
        end
      end
      START: begin
        if (cnt == HALF) begin
          cnt_n     = '0;
          bit_cnt_n = '0;
          state_n   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          shreg_n   = {rx_s, shreg[DATA_BITS-1:1]};
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) state_n = PARITY_EN ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (cnt == LAST) begin
          par_bad_n = ((^shreg) != rx_s);
          state_n   = STOP;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          state_n = IDLE;
          if (!rx_s)        frame_evt = 1'b1;
          else if (par_bad) par_evt   = 1'b1;
          else              good      = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Holding register: a consuming handshake frees the slot in the same cycle,
  // so a byte completing alongside it loads without an overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_data   <= '0;
      hold_valid  <= 1'b0;
      err_parity  <= 1'b0;
      err_frame   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (good && (!hold_valid || dec.out_ready)) begin
        hold_data  <= shreg;
        hold_valid <= 1'b1;
      end else if (hold_valid && dec.out_ready) begin
        hold_valid <= 1'b0;
      end
      // Set after clear so a same-cycle error event wins.
      if (clear_err) begin
        err_parity  <= 1'b0;
        err_frame   <= 1'b0;
        err_overrun <= 1'b0;
      end
      if (par_evt)                                    err_parity  <= 1'b1;
      if (frame_evt)                                  err_frame   <= 1'b1;
      if (good && hold_valid && !dec.out_ready)       err_overrun <= 1'b1;
    end
  end

  assign dec.out_data  = hold_data;
  assign dec.out_valid = hold_valid;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_code_frame_rx.sv
// Self-checking bench for code_frame_rx (CLKS_PER_BIT=4, PARITY_EN=1).
// A frame-level model predicts when each frame's outcome lands and what the
// holding register and sticky flags must show; a compare process checks the
// DUT against it every cycle, and directed checks pin literal expectations.
module tb_code_frame_rx;
  import code_rx_pkg::*;

  localparam int unsigned CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_in = 1'b1;
  logic clear_err = 1'b0;
  logic err_parity, err_frame, err_overrun, busy;

  code_frame_rx_if dec_if ();

  code_frame_rx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .dec         (dec_if),
    .err_parity  (err_parity),
    .err_frame   (err_frame),
    .err_overrun (err_overrun),
    .clear_err   (clear_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- frame-level model ----------------
  typedef enum {EV_GOOD, EV_PAR, EV_FRAME} ev_kind_t;
  typedef struct {
    int        e;
    ev_kind_t  kind;
    logic [7:0] b;
  } ev_t;
  ev_t evq[$];

  logic rst_q = 1'b1, rdy_q = 1'b0, clr_q = 1'b0;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
    rdy_q <= dec_if.out_ready;
    clr_q <= clear_err;
  end

  logic       m_v, m_fp, m_ff, m_fo;
  logic [7:0] m_d;
  int         vcount = 0;
  logic [7:0] last_d = '0;

  initial begin
    ev_t ev;
    bit  have;
    forever begin
      @(negedge clk);
      if (rst_q) begin
        m_v = 0; m_d = '0; m_fp = 0; m_ff = 0; m_fo = 0;
        evq.delete();
      end else begin
        have = 0;
        if (evq.size() > 0 && evq[0].e == cyc) begin
          ev = evq.pop_front();
          have = 1;
        end
        if (clr_q) begin m_fp = 0; m_ff = 0; m_fo = 0; end
        if (have && ev.kind == EV_GOOD) begin
          if (!m_v || rdy_q) begin m_d = ev.b; m_v = 1; end
          else m_fo = 1;
        end else if (m_v && rdy_q) begin
          m_v = 0;
        end
        if (have && ev.kind == EV_PAR)   m_fp = 1;
        if (have && ev.kind == EV_FRAME) m_ff = 1;
      end
      chk("out_valid",   32'(dec_if.out_valid), 32'(m_v));
      chk("out_data",    32'(dec_if.out_data),  32'(m_d));
      chk("err_parity",  32'(err_parity),       32'(m_fp));
      chk("err_frame",   32'(err_frame),        32'(m_ff));
      chk("err_overrun", 32'(err_overrun),      32'(m_fo));
      if (dec_if.out_valid === 1'b1) begin
        vcount++;
        last_d = dec_if.out_data;
      end
    end
  end

  // ---------------- stimulus ----------------
  int prev_end = -1000;
  int prev_e   = 0;
  bit prev_stop_low = 0;

  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Outcome lands one cycle after the mid-stop-bit sample, which is seen 2
  // cycles late through the synchronizer. If the previous stop bit was low and
  // this frame follows with no gap, the receiver is already looking at a low
  // line when it returns to idle, so it locks on one cycle after that sample.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp);
    int p0, d, e;
    ev_kind_t k;
    logic [10:0] bits;
    p0 = cyc + 1;
    d  = (prev_stop_low && p0 == prev_end) ? prev_e + 1 : p0 + 2;
    e  = d + CPB / 2 + (DATA_BITS + 2) * CPB;
    if (!stp)           k = EV_FRAME;
    else if (par != ^b) k = EV_PAR;
    else                k = EV_GOOD;
    evq.push_back('{e: e, kind: k, b: b});
    prev_end      = p0 + 11 * CPB;
    prev_e        = e;
    prev_stop_low = !stp;
    bits = {stp, par, b, 1'b0};
    for (int i = 0; i < 11; i++) drive_bit(bits[i]);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, ^b, b, 1'b0};
    for (int i = 0; i < nbits; i++) drive_bit(bits[i]);
    prev_stop_low = 0;
  endtask

  initial begin
    int v0, bc;
    dec_if.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("reset_busy",  32'(busy), 0);
    chk("reset_valid", 32'(dec_if.out_valid), 0);
    chk("reset_data",  32'(dec_if.out_data), 0);
    chk("reset_flags", 32'({err_parity, err_frame, err_overrun}), 0);
    rst = 1'b0;
    idle(6);

    // good byte, single-cycle valid pulse
    v0 = vcount;
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(6); #2;
    chk("a5_pulses", 32'(vcount - v0), 1);
    chk("a5_data",   32'(last_d), 32'hA5);
    chk("a5_flags",  32'({err_parity, err_frame, err_overrun}), 0);

    // wrong parity, then clear
    v0 = vcount;
    send_frame(8'h3C, 1'b1, 1'b1);
    idle(6); #2;
    chk("par_no_valid", 32'(vcount - v0), 0);
    chk("par_flag",     32'(err_parity), 1);
    @(negedge clk); clear_err = 1'b1;
    @(negedge clk); clear_err = 1'b0;
    #2;
    chk("par_cleared",  32'(err_parity), 0);

    // stop bit low, followed with no gap by a good frame
    v0 = vcount;
    send_frame(8'h55, 1'b0, 1'b0);
    send_frame(8'h0F, 1'b0, 1'b1);
    idle(6); #2;
    chk("frame_flag",   32'(err_frame), 1);
    chk("b2b_pulses",   32'(vcount - v0), 1);
    chk("b2b_data",     32'(last_d), 32'h0F);
    @(negedge clk); clear_err = 1'b1;
    @(negedge clk); clear_err = 1'b0;

    // one-cycle glitch: busy for half a bit only
    v0 = vcount;
    rx_in = 1'b0;
    @(negedge clk); rx_in = 1'b1;
    bc = 0;
    repeat (8) begin
      @(negedge clk); #1;
      if (busy === 1'b1) bc++;
    end
    chk("glitch_busy_cycles", 32'(bc), 2);
    chk("glitch_idle",        32'(busy), 0);
    chk("glitch_no_valid",    32'(vcount - v0), 0);
    chk("glitch_flags",       32'({err_parity, err_frame, err_overrun}), 0);

    // overrun with decoder stalled
    @(negedge clk); dec_if.out_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    idle(6); #2;
    chk("ovr_valid", 32'(dec_if.out_valid), 1);
    chk("ovr_data",  32'(dec_if.out_data), 32'h11);
    chk("ovr_flag",  32'(err_overrun), 1);
    @(negedge clk); dec_if.out_ready = 1'b1;
    @(negedge clk); #2;
    chk("ovr_consumed", 32'(dec_if.out_valid), 0);
    chk("ovr_held",     32'(dec_if.out_data), 32'h11);

    // reset in the middle of DATA
    @(negedge clk);
    send_partial(8'h99, 5);
    rst = 1'b1; rx_in = 1'b1;
    @(negedge clk); #2;
    chk("mid_rst_busy",  32'(busy), 0);
    chk("mid_rst_valid", 32'(dec_if.out_valid), 0);
    chk("mid_rst_data",  32'(dec_if.out_data), 0);
    chk("mid_rst_flags", 32'({err_parity, err_frame, err_overrun}), 0);
    rst = 1'b0;
    idle(6);
    v0 = vcount;
    send_frame(8'h99, 1'b0, 1'b1);
    idle(6); #2;
    chk("post_rst_pulses", 32'(vcount - v0), 1);
    chk("post_rst_data",   32'(last_d), 32'h99);
    chk("post_rst_flags",  32'({err_parity, err_frame, err_overrun}), 0);

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/code_frame_rx.md
Name: code_frame_rx

Overview:
- Serial front-end that feeds the decoder stage.
- Receives asynchronous framed serial code words on a single input pin: 1 start bit, 8 data bits LSB first, optional even parity bit, 1 stop bit.
- Delivers each good byte to the decoder through a one-entry valid/ready holding register.
- Flags parity, framing and overrun errors for status readback on uo/uio pins.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit; must be even and >= 4.
- PARITY_EN, 1: 1 expects an even-parity bit after data; 0 means no parity bit.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- rx_in  input  1  raw asynchronous serial line; idle high
- out_data  output  8  received byte presented to decoder
- out_valid  output  1  out_data holds an unconsumed byte
- out_ready  input  1  decoder accepts byte when out_valid && out_ready
- err_parity  output  1  sticky: parity mismatch seen
- err_frame  output  1  sticky: stop bit low seen
- err_overrun  output  1  sticky: good byte dropped because holding register was full
- clear_err  input  1  synchronous clear of all three sticky flags
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0; FSM in IDLE; holding register 0; bit counter and tick counter 0.
- Reset mid-frame aborts the frame with no error flagged.
- Input conditioning: rx_in passes through a 2-FF synchronizer (rx_s), which adds 2 cycles of latency. No glitch filtering beyond mid-bit sampling.
- Tick counter: width $clog2(CLKS_PER_BIT). It is reloaded on each state entry and counts to CLKS_PER_BIT-1, then wraps to 0.
- IDLE: stay while rx_s==1. When rx_s==0, go to START and reload the counter.
- START: at count CLKS_PER_BIT/2-1 (mid-bit), sample rx_s.
  - Sample 1: false start; return to IDLE with no flag.
  - Sample 0: go to DATA and realign so that later samples fall every CLKS_PER_BIT cycles.
- DATA: sample 8 bits at mid-bit. Shift right so the first bit lands in bit 0. After the 8th sample go to PARITY if PARITY_EN=1, else to STOP.
- PARITY: sample one bit. Mismatch when (XOR of data bits) != sampled bit; record the mismatch internally. Then go to STOP.
- STOP: sample the stop bit.
  - Sample 0: set err_frame, discard the byte, go to IDLE.
  - Sample 1 with a parity mismatch: set err_parity, discard the byte, go to IDLE.
  - Sample 1 with no mismatch: the byte is good; go to IDLE.
  - IDLE is re-entered immediately, so back-to-back frames are accepted with no gap beyond the stop bit.
- Good-byte delivery: on the cycle after the stop-bit sample, out_data is loaded and out_valid=1.
  - out_valid stays high until the handshake (out_valid && out_ready) completes.
  - out_data stays stable while out_valid=1.
- Handshake consumed with no new byte completing that cycle: out_valid goes 0 on the next edge.
- Simultaneous handshake and new good byte: the new byte loads and out_valid stays 1. No overrun.
- New good byte while out_valid=1 && !out_ready: the new byte is dropped, the old byte is kept, and err_overrun is set.
- Sticky flags:
  - Cleared when clear_err=1.
  - If clear_err is asserted in the same cycle that an error event occurs, the set wins.
  - Flags never self-clear.
- busy = (state != IDLE).

Decomposition:
- Shared package code_rx_pkg:
  - state encoding: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4 (3 bits)
  - DATA_BITS=8
  - function for tick counter width
- Sub-module sync_ff2: a 2-flop synchronizer with a synchronous active-high reset value of 1 (line idle). It is reused for other async pins.

Test Plan:
- CLKS_PER_BIT=4, PARITY_EN=1, send 0xA5 with parity 0 and stop 1, out_ready=1 -> out_valid pulses for 1 cycle with out_data=0xA5; all err_* stay 0.
- Send 0x3C with parity bit 1 (wrong) -> no out_valid; err_parity=1. Pulse clear_err -> err_parity=0.
- Send 0x55 with stop bit 0 -> no out_valid; err_frame=1. A following 0x0F frame with gap 0 is received correctly.
- Drive a 1-cycle low glitch on rx_in -> FSM returns to IDLE after half a bit; no flags; no out_valid.
- Hold out_ready=0 and send 0x11 then 0x22 -> out_data=0x11 held, err_overrun=1. Raise out_ready -> 0x11 consumed, out_valid=0.
- Assert rst midway through DATA of 0x99 -> on the next edge busy=0 and all outputs 0. A fresh 0x99 frame afterwards is received correctly.
